// File: rtl/wave_dma_server.sv
// rtl/wave_dma_server.sv - line-buffered byte-read DMA responder for wave player channels
module wave_dma_server #(
  parameter int CHANNELS = 8,
  parameter int ADDR_W   = 28
) (
  input  logic                       I_CLK,
  input  logic                       I_RST,
  input  logic [CHANNELS-1:0]        I_CH_READ,
  input  logic [CHANNELS*ADDR_W-1:0] I_CH_ADDR,
  output logic [CHANNELS*8-1:0]      O_CH_DATA,
  output logic [CHANNELS-1:0]        O_CH_READY,
  input  logic                       I_INVALIDATE,
  output logic [ADDR_W-4:0]          O_MEM_ADDR,
  output logic                       O_MEM_RD,
  input  logic                       I_MEM_BUSY,
  input  logic [63:0]                I_MEM_DOUT,
  input  logic                       I_MEM_DOUT_READY
);
  localparam int WA_W = ADDR_W - 3;
  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FILL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cur_q, cur_d, rr_q, rr_d;
  logic [WA_W-1:0] issued_q, issued_d;
  logic            discard_q, discard_d;

  logic [ADDR_W-1:0]   req_addr_q  [CHANNELS];
  logic [ADDR_W-1:0]   req_addr_d  [CHANNELS];
  logic [WA_W-1:0]     line_tag_q  [CHANNELS];
  logic [WA_W-1:0]     line_tag_d  [CHANNELS];
  logic [63:0]         line_data_q [CHANNELS];
  logic [63:0]         line_data_d [CHANNELS];
  logic [7:0]          ch_data_q   [CHANNELS];
  logic [7:0]          ch_data_d   [CHANNELS];
  logic [CHANNELS-1:0] line_valid_q, line_valid_d;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] ready_q, ready_d;

  logic          fill_write, fill_serve, found;
  logic [CW-1:0] idx;

  // Miss-service FSM: round-robin pick, issue one word read, wait for data, re-check on fill
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rr_d       = rr_q;
    issued_d   = issued_q;
    discard_d  = discard_q;
    O_MEM_RD   = 1'b0;
    fill_write = 1'b0;
    fill_serve = 1'b0;
    found      = 1'b0;
    idx        = '0;
    case (state_q)
      S_IDLE: begin
        for (int i = 0; i < CHANNELS; i++) begin
          idx = CW'((int'(rr_q) + i) % CHANNELS);
          if (!found && pending_q[idx]) begin
            found = 1'b1;
            cur_d = idx;
          end
        end
        if (found) begin
          discard_d = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        O_MEM_RD = 1'b1;
        if (I_INVALIDATE) discard_d = 1'b1;
        if (!I_MEM_BUSY) begin
          // the word in flight is frozen here; later re-strobes only affect the FILL re-check
          issued_d = req_addr_q[cur_q][ADDR_W-1:3];
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (I_INVALIDATE) discard_d = 1'b1;
        if (I_MEM_DOUT_READY) begin
          fill_write = !discard_q && !I_INVALIDATE;
          state_d    = S_FILL;
        end
      end
      default: begin
        fill_serve = !discard_q && !I_INVALIDATE &&
                     (req_addr_q[cur_q][ADDR_W-1:3] == issued_q);
        rr_d    = (cur_q == CW'(CHANNELS - 1)) ? '0 : cur_q + 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // Per-channel line buffers: invalidate, fill, fill-time serve, then strobes (latest wins)
  always_comb begin
    req_addr_d   = req_addr_q;
    line_tag_d   = line_tag_q;
    line_data_d  = line_data_q;
    ch_data_d    = ch_data_q;
    line_valid_d = line_valid_q;
    pending_d    = pending_q;
    ready_d      = ready_q;
    if (I_INVALIDATE) line_valid_d = '0;
    if (fill_write) begin
      line_data_d[cur_q]  = I_MEM_DOUT;
      line_tag_d[cur_q]   = issued_q;
      line_valid_d[cur_q] = 1'b1;
    end
    if (fill_serve) begin
      ch_data_d[cur_q] = line_data_q[cur_q][{req_addr_q[cur_q][2:0], 3'b000} +: 8];
      ready_d[cur_q]   = 1'b1;
      pending_d[cur_q] = 1'b0;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (I_CH_READ[c]) begin
        req_addr_d[c] = I_CH_ADDR[c*ADDR_W +: ADDR_W];
        if (!I_INVALIDATE && line_valid_q[c] &&
            line_tag_q[c] == I_CH_ADDR[c*ADDR_W+3 +: WA_W]) begin
          ch_data_d[c] = line_data_q[c][{I_CH_ADDR[c*ADDR_W +: 3], 3'b000} +: 8];
          ready_d[c]   = 1'b1;
          pending_d[c] = 1'b0;
        end else begin
          ready_d[c]   = 1'b0;
          pending_d[c] = 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      rr_q         <= '0;
      issued_q     <= '0;
      discard_q    <= 1'b0;
      req_addr_q   <= '{default: '0};
      line_tag_q   <= '{default: '0};
      line_data_q  <= '{default: '0};
      ch_data_q    <= '{default: '0};
      line_valid_q <= '0;
      pending_q    <= '0;
      ready_q      <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      rr_q         <= rr_d;
      issued_q     <= issued_d;
      discard_q    <= discard_d;
      req_addr_q   <= req_addr_d;
      line_tag_q   <= line_tag_d;
      line_data_q  <= line_data_d;
      ch_data_q    <= ch_data_d;
      line_valid_q <= line_valid_d;
      pending_q    <= pending_d;
      ready_q      <= ready_d;
    end
  end

  // Output packing; the address shows the live request while issuing, else the last issued word
  always_comb begin
    O_CH_DATA = '0;
    for (int c = 0; c < CHANNELS; c++) O_CH_DATA[c*8 +: 8] = ch_data_q[c];
    O_CH_READY = ready_q;
    O_MEM_ADDR = (state_q == S_ISSUE) ? req_addr_q[cur_q][ADDR_W-1:3] : issued_q;
  end

endmodule

// File: tb/tb_wave_dma_server.sv
// tb/tb_wave_dma_server.sv - scoreboard bench for wave_dma_server
module tb_wave_dma_server;
  localparam int CH = 8;
  localparam int AW = 28;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    ch_read;
  logic [CH*AW-1:0] ch_addr;
  logic [CH*8-1:0]  ch_data;
  logic [CH-1:0]    ch_ready;
  logic             inval;
  logic [AW-4:0]    mem_addr;
  logic             mem_rd;
  logic             mem_busy = 1'b0;
  logic [63:0]      mem_dout = '0;
  logic             mem_dout_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [7:0]    exp_q [CH][$];
  logic [AW-4:0] issued [$];
  logic [AW-1:0] stb_addr [CH];
  logic [AW-4:0] ret_word;
  logic [7:0]    mon_e;
  int            ret_cnt = 0;
  int            ret_lat = 2;
  int            force_busy = 0;
  bit            rand_busy = 0;

  wave_dma_server #(.CHANNELS(CH), .ADDR_W(AW)) dut (
    .I_CLK(clk), .I_RST(rst), .I_CH_READ(ch_read), .I_CH_ADDR(ch_addr),
    .O_CH_DATA(ch_data), .O_CH_READY(ch_ready), .I_INVALIDATE(inval),
    .O_MEM_ADDR(mem_addr), .O_MEM_RD(mem_rd), .I_MEM_BUSY(mem_busy),
    .I_MEM_DOUT(mem_dout), .I_MEM_DOUT_READY(mem_dout_ready)
  );

  always #5 clk = ~clk;

  // memory contents: word 2 holds 0x8877665544332211, everything else a byte hash
  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    if (a[AW-1:3] == 25'd2) return 8'h11 * {5'd0, a[2:0]} + 8'h11;
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A ^ {a[2:0], 5'd0};
  endfunction

  function automatic logic [63:0] mem_word(input logic [AW-4:0] w);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = mem_byte({w, 3'(k)});
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_strobe(input logic [CH-1:0] mask, input logic inv);
    for (int c = 0; c < CH; c++) if (mask[c]) ch_addr[c*AW +: AW] = stb_addr[c];
    ch_read = mask;
    inval   = inv;
    @(posedge clk);
    for (int c = 0; c < CH; c++) if (mask[c]) exp_q[c].push_back(mem_byte(stb_addr[c]));
    #1;
    ch_read = '0;
    inval   = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    bit busy;
    k = 0;
    busy = 1;
    while (busy && k < budget) begin
      busy = 0;
      for (int c = 0; c < CH; c++) if (exp_q[c].size() != 0) busy = 1;
      if (busy) begin
        tick();
        k++;
      end
    end
    check(name, 64'(busy), 0);
    repeat (10) tick();
  endtask

  task automatic wait_issued(input string name, input int n);
    int k;
    k = 0;
    while (issued.size() < n && k < 100) begin
      tick();
      k++;
    end
    check(name, 64'(issued.size() >= n), 1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < CH; c++) exp_q[c].delete();
    issued.delete();
  endtask

  // DDRAM model: busy generation, acceptance log, fixed-latency return
  always @(negedge clk) begin
    if (force_busy > 0) begin
      mem_busy = 1'b1;
      force_busy--;
    end else begin
      mem_busy = rand_busy && ($urandom_range(3) == 0);
    end
    if (rst) begin
      ret_cnt = 0;
      mem_dout_ready = 1'b0;
    end else begin
      mem_dout_ready = 1'b0;
      if (ret_cnt > 0) begin
        ret_cnt--;
        if (ret_cnt == 0) begin
          mem_dout = mem_word(ret_word);
          mem_dout_ready = 1'b1;
        end
      end
      if (mem_rd && !mem_busy) begin
        check("one_outstanding", 64'(ret_cnt), 0);
        issued.push_back(mem_addr);
        ret_word = mem_addr;
        ret_cnt  = ret_lat;
      end
    end
  end

  // Scoreboard monitor: READY=1 means DATA belongs to the channel's latest request
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        if (ch_ready[c] && exp_q[c].size() > 0) begin
          mon_e = exp_q[c][$];
          exp_q[c].delete();
          check($sformatf("ch%0d_data", c), 64'(ch_data[c*8 +: 8]), 64'(mon_e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int lat;
    int k;
    rst = 1'b1;
    ch_read = '0;
    ch_addr = '0;
    inval = 1'b0;
    for (int c = 0; c < CH; c++) stb_addr[c] = '0;
    tick();
    tick();
    check("rst_data", ch_data, 0);
    check("rst_ready", 64'(ch_ready), 0);
    check("rst_mem_rd", 64'(mem_rd), 0);
    check("rst_mem_addr", 64'(mem_addr), 0);
    rst = 1'b0;
    tick();

    // first miss and its latency
    stb_addr[0] = 28'h0000010;
    do_strobe(8'h01, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ch_ready[0] && lat < 40);
    check("t1_latency", 64'(lat), 6);
    tick();
    drain("t1_drain", 50);
    check("t1_nreq", 64'(issued.size()), 1);
    check("t1_addr", 64'(issued[0]), 2);

    // sequential hits on the same line
    for (int b = 1; b < 8; b++) begin
      stb_addr[0] = 28'h0000010 + 28'(b);
      do_strobe(8'h01, 1'b0);
      check("t2_ready", 64'(ch_ready[0]), 1);
    end
    tick();
    check("t2_no_rd", 64'(issued.size()), 1);

    // all channels at once, port busy for 5 cycles
    reset_dut();
    force_busy = 5;
    for (int c = 0; c < CH; c++) stb_addr[c] = 28'h0001000 + 28'(c) * 28'h48;
    do_strobe(8'hFF, 1'b0);
    check("t3_ready_low", 64'(ch_ready), 0);
    drain("t3_drain", 400);
    check("t3_nreq", 64'(issued.size()), 8);
    for (int c = 0; c < CH; c++)
      check($sformatf("t3_order%0d", c), 64'(issued[c]), 64'(stb_addr[c][AW-1:3]));

    // re-strobe on the selected channel while its read is outstanding
    issued.delete();
    ret_lat = 4;
    stb_addr[3] = 28'h100;
    do_strobe(8'h08, 1'b0);
    wait_issued("t4_first", 1);
    stb_addr[3] = 28'h208;
    do_strobe(8'h08, 1'b0);
    drain("t4_drain", 100);
    check("t4_nreq", 64'(issued.size()), 2);
    check("t4_word0", 64'(issued[0]), 64'h20);
    check("t4_word1", 64'(issued[1]), 64'h41);

    // invalidate during WAIT discards the fill
    issued.delete();
    ret_lat = 4;
    stb_addr[1] = 28'h3C8;
    do_strobe(8'h02, 1'b0);
    wait_issued("t5_first", 1);
    do_strobe(8'h00, 1'b1);
    drain("t5_drain", 100);
    check("t5_nreq", 64'(issued.size()), 2);
    check("t5_reissue", 64'(issued[1]), 64'h79);
    ret_lat = 2;
    stb_addr[1] = 28'h3C9;
    do_strobe(8'h02, 1'b0);
    check("t5_hit_ready", 64'(ch_ready[1]), 1);
    do_strobe(8'h00, 1'b1);
    check("t5_inv_keeps_ready", 64'(ch_ready[1]), 1);
    stb_addr[1] = 28'h3CA;
    do_strobe(8'h02, 1'b0);
    check("t5_miss_ready", 64'(ch_ready[1]), 0);
    drain("t5_drain2", 100);
    check("t5_nreq2", 64'(issued.size()), 3);

    // reset while a request is held in ISSUE
    stb_addr[0] = 28'h10;
    do_strobe(8'h01, 1'b0);
    drain("t6_pre", 100);
    force_busy = 1000;
    stb_addr[2] = 28'h500;
    do_strobe(8'h04, 1'b0);
    k = 0;
    while (!mem_rd && k < 50) begin
      tick();
      k++;
    end
    check("t6_issue", 64'(mem_rd), 1);
    rst = 1'b1;
    tick();
    check("t6_rd_low", 64'(mem_rd), 0);
    check("t6_ready_low", 64'(ch_ready), 0);
    check("t6_data_low", ch_data, 0);
    rst = 1'b0;
    force_busy = 0;
    for (int c = 0; c < CH; c++) exp_q[c].delete();
    issued.delete();
    tick();
    do_strobe(8'h04, 1'b0);
    check("t6_fresh_miss", 64'(ch_ready[2]), 0);
    drain("t6_drain", 100);
    check("t6_nreq", 64'(issued.size()), 1);
    check("t6_addr", 64'(issued[0]), 64'hA0);

    // randomized traffic over a small word pool, random port busy and latency
    rand_busy = 1;
    for (int it = 0; it < 300; it++) begin
      logic [CH-1:0] mask;
      mask = CH'($urandom & $urandom & $urandom);
      for (int c = 0; c < CH; c++)
        stb_addr[c] = {25'(28'h300 + 28'($urandom_range(5))), 3'($urandom_range(7))};
      ret_lat = $urandom_range(1, 4);
      do_strobe(mask, 1'b0);
    end
    drain("rand_drain", 3000);
    rand_busy = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
